// File: rtl/i2s_rx_stereo.sv
// I2S receiver: synchronizes SCK/WS/SD, captures left/right words and
// queues completed frames in a show-ahead FIFO with valid/ready output.
module i2s_rx_stereo #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             sck_i,
    input  logic                             ws_i,
    input  logic                             sd_i,
    output logic [DATA_W-1:0]                left_o,
    output logic [DATA_W-1:0]                right_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o,
    output logic                             overflow_o,
    input  logic                             clear_i
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int FRM_W = 2 * DATA_W;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic             r_sck_s1, r_sck_s2, r_sck_s3;
    logic             r_ws_s1, r_ws_s2;
    logic             r_sd_s1, r_sd_s2;
    logic             r_ws_prev;
    logic             r_synced;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_left_hold;
    logic             r_hold_v;

    logic [FRM_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    logic              w_rise;
    logic              w_slot_end;
    logic              w_emit;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] w_word;
    logic              w_push;
    logic [FRM_W-1:0]  w_frame;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;
    logic [FRM_W-1:0]  w_head;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_s3 <= 1'b0;
            r_ws_s1  <= 1'b0;
            r_ws_s2  <= 1'b0;
            r_sd_s1  <= 1'b0;
            r_sd_s2  <= 1'b0;
        end else begin
            r_sck_s1 <= sck_i;
            r_sck_s2 <= r_sck_s1;
            r_sck_s3 <= r_sck_s2;
            r_ws_s1  <= ws_i;
            r_ws_s2  <= r_ws_s1;
            r_sd_s1  <= sd_i;
            r_sd_s2  <= r_sd_s1;
        end
    end

    assign w_rise     = r_sck_s2 & ~r_sck_s3;
    assign w_slot_end = w_rise & (r_ws_s2 != r_ws_prev);
    assign w_emit     = w_slot_end & r_synced;

    // The bit sampled on the WS-change rise still belongs to the ending slot
    always_comb begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
        if (r_bit_cnt < CNT_MAX) begin
            w_shift_nxt = {r_shift[DATA_W-2:0], r_sd_s2};
            w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
        end
    end

    assign w_word = w_shift_nxt << (CNT_MAX - w_cnt_nxt);

    always_comb begin
        w_push  = 1'b0;
        w_frame = '0;
        if (w_emit) begin
            if (MODE == 0) begin
                w_push  = ~r_ws_prev;
                w_frame = {w_word, {DATA_W{1'b0}}};
            end else if (MODE == 1) begin
                w_push  = r_ws_prev;
                w_frame = {{DATA_W{1'b0}}, w_word};
            end else begin
                w_push  = r_ws_prev & r_hold_v;
                w_frame = {r_left_hold, w_word};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ws_prev <= 1'b0;
            r_synced  <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_rise) begin
            if (w_slot_end) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_ws_prev <= r_ws_s2;
                r_synced  <= 1'b1;
            end else begin
                r_bit_cnt <= w_cnt_nxt;
                r_shift   <= w_shift_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_left_hold <= '0;
            r_hold_v    <= 1'b0;
        end else if (w_emit && MODE == 2) begin
            if (!r_ws_prev) begin
                r_left_hold <= w_word;
                r_hold_v    <= 1'b1;
            end else begin
                r_hold_v    <= 1'b0;
            end
        end
    end

    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = valid_o & ready_i;
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_frame;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop in the same cycle as clear_i keeps the flag set
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign valid_o    = (r_level != '0);
    assign level_o    = r_level;
    assign overflow_o = r_overflow;
    assign left_o     = (valid_o && MODE != 1) ? w_head[FRM_W-1:DATA_W] : '0;
    assign right_o    = (valid_o && MODE != 0) ? w_head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Bench for i2s_rx_stereo: a 24-bit stereo instance and a 16-bit
// left-only instance share one I2S bus; frames are checked via scoreboards.
module tb_i2s_rx_stereo;

    logic clk = 1'b0;
    logic rst;
    logic sck, ws, sd;

    logic [23:0] a_left, a_right;
    logic        a_valid, a_ready, a_ovf, a_clear;
    logic [2:0]  a_level;

    logic [15:0] b_left, b_right;
    logic        b_valid, b_ready, b_ovf, b_clear;
    logic [2:0]  b_level;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    i2s_rx_stereo #(.DATA_W(24), .FIFO_DEPTH(4), .MODE(2)) u_a (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .left_o(a_left), .right_o(a_right), .valid_o(a_valid),
        .ready_i(a_ready), .level_o(a_level), .overflow_o(a_ovf),
        .clear_i(a_clear)
    );

    i2s_rx_stereo #(.DATA_W(16), .FIFO_DEPTH(4), .MODE(0)) u_b (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .left_o(b_left), .right_o(b_right), .valid_o(b_valid),
        .ready_i(b_ready), .level_o(b_level), .overflow_o(b_ovf),
        .clear_i(b_clear)
    );

    typedef struct {
        logic [31:0] ls;
        int          lb;
        logic [31:0] rs;
        int          rb;
        logic [23:0] el;
        logic [23:0] er;
    } vec_t;

    vec_t tbl [6];

    bit          synced;
    bit          holdv;
    bit          a_drop;
    logic [23:0] hold_a;
    logic [47:0] q_a [$];
    logic [31:0] q_b [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Left-aligned capture of an n-bit MSB-first slot into a w-bit word
    function automatic logic [31:0] cap(input logic [31:0] sv,
                                        input int n, input int w);
        logic [63:0] t;
        t = {32'h0, sv};
        if (n >= w) t = t >> (n - w);
        else        t = t << (w - n);
        t = t & ((64'h1 << w) - 64'h1);
        return t[31:0];
    endfunction

    function automatic logic [23:0] w24(input logic [31:0] sv, input int n);
        logic [31:0] t;
        t = cap(sv, n, 24);
        return t[23:0];
    endfunction

    task automatic slot_done(input bit ch, input logic [31:0] sv,
                             input int n, input logic [23:0] wa);
        logic [31:0] wb;
        if (!synced) begin
            synced = 1'b1;
        end else if (!ch) begin
            hold_a = wa;
            holdv  = 1'b1;
            wb     = cap(sv, n, 16);
            q_b.push_back({wb[15:0], 16'h0});
        end else begin
            if (holdv && !a_drop) q_a.push_back({hold_a, wa});
            holdv = 1'b0;
        end
    endtask

    // tap 1: one-cycle pop pulse at the push edge; tap 2: latency probe
    task automatic drive_bit(input bit w, input bit d, input int tap);
        ws = w;
        sd = d;
        repeat (4) @(posedge clk);
        #1 sck = 1'b1;
        if (tap == 1) begin
            @(posedge clk); #1;
            @(posedge clk); #1 a_ready = 1'b1;
            @(posedge clk); #1 a_ready = 1'b0;
            @(posedge clk); #1;
        end else if (tap == 2) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("lat_early_valid", a_valid, 1'b0);
            @(posedge clk); #1;
            chk("lat_valid", a_valid, 1'b1);
            chk("lat_level", a_level, 3'd1);
            @(posedge clk); #1;
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
        sck = 1'b0;
    endtask

    task automatic send_slot(input bit ch, input logic [31:0] sv, input int n,
                             input logic [23:0] wa, input int tap);
        for (int i = n - 1; i >= 0; i--) begin
            if (i == 0) slot_done(ch, sv, n, wa);
            drive_bit((i == 0) ? ~ch : ch, sv[i], (i == 0) ? tap : 0);
        end
    endtask

    task automatic send_pair(input int k, input int tap);
        send_slot(1'b0, tbl[k].ls, tbl[k].lb, tbl[k].el, 0);
        send_slot(1'b1, tbl[k].rs, tbl[k].rb, tbl[k].er, tap);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_qa_empty"}, q_a.size(), 0);
        chk({nm, "_qb_empty"}, q_b.size(), 0);
        chk({nm, "_a_level"}, a_level, 3'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a_valid"}, a_valid, 1'b0);
        chk({nm, "_a_level"}, a_level, 3'd0);
        chk({nm, "_a_ovf"}, a_ovf, 1'b0);
        chk({nm, "_a_left"}, a_left, 24'h0);
        chk({nm, "_a_right"}, a_right, 24'h0);
        chk({nm, "_b_valid"}, b_valid, 1'b0);
        chk({nm, "_b_left"}, b_left, 16'h0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid && a_ready) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_frame", {a_left, a_right}, 48'hx);
                end else begin
                    logic [47:0] e;
                    e = q_a.pop_front();
                    chk("a_frame", {a_left, a_right}, e);
                end
            end
            if (b_valid && b_ready) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_frame", {b_left, b_right}, 32'hx);
                end else begin
                    logic [31:0] e;
                    e = q_b.pop_front();
                    chk("b_frame", {b_left, b_right}, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'hA5A5A500, 32, 32'h12345600, 32, 24'hA5A5A5, 24'h123456};
        tbl[1] = '{32'hBEEFFFFF, 32, 32'h0F0F0F0F, 32, 24'hBEEFFF, 24'h0F0F0F};
        tbl[2] = '{32'h0000ABCD, 16, 32'h00005A5A, 16, 24'hABCD00, 24'h5A5A00};
        tbl[3] = '{32'hFFFFFFFF, 32, 32'h00000001, 32, 24'hFFFFFF, 24'h000000};
        tbl[4] = '{32'h80000000, 32, 32'hDEADBEEF, 32, 24'h800000, 24'hDEADBE};
        tbl[5] = '{32'h000FEDCB, 20, 32'h00654321, 24, 24'hFEDCB0, 24'h654321};

        rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        a_ready = 1'b1; a_clear = 1'b0;
        b_ready = 1'b1; b_clear = 1'b0;
        synced = 1'b0; holdv = 1'b0; a_drop = 1'b0; hold_a = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // First slot only arms; the following right slot has no left partner
        send_slot(1'b0, 32'h13572468, 32, 24'h0, 0);
        send_slot(1'b1, 32'h77777777, 32, w24(32'h77777777, 32), 0);

        for (int k = 0; k < 6; k++) send_pair(k, 0);
        drain("table");

        a_ready = 1'b0;
        send_pair(0, 2);
        a_ready = 1'b1;
        drain("latency");

        a_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_pair(k, 0);
        chk("bp_level4", a_level, 3'd4);
        chk("bp_no_ovf_yet", a_ovf, 1'b0);
        chk("bp_head_stable", a_left, tbl[0].el);
        a_drop = 1'b1;
        send_pair(4, 0);
        a_drop = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_level_full", a_level, 3'd4);
        chk("bp_overflow", a_ovf, 1'b1);
        a_ready = 1'b1;
        drain("bp");
        chk("bp_ovf_sticky", a_ovf, 1'b1);
        a_clear = 1'b1;
        @(posedge clk); #1 a_clear = 1'b0;
        chk("bp_ovf_cleared", a_ovf, 1'b0);

        a_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_pair(k + 1, 0);
        send_pair(5, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("full_pop_level", a_level, 3'd4);
        chk("full_pop_ovf", a_ovf, 1'b0);
        a_ready = 1'b1;
        drain("full_pop");

        a_ready = 1'b0;
        send_pair(2, 0);
        send_slot(1'b0, 32'hCCCCCCCC, 32, w24(32'hCCCCCCCC, 32), 0);
        for (int i = 0; i < 10; i++) drive_bit(1'b1, i[0], 0);
        @(posedge clk); #1 rst = 1'b1;
        q_a.delete();
        q_b.delete();
        synced = 1'b0;
        holdv  = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        a_ready = 1'b1;
        // WS is high after reset, so the first rise is the arming transition
        synced = 1'b1;
        drive_bit(1'b1, 1'b1, 0);
        send_slot(1'b1, 32'h000ABCDE, 20, w24(32'h000ABCDE, 20), 0);
        send_pair(1, 0);
        drain("post_rst");
        chk("post_rst_ovf", a_ovf, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/i2s_rx_stereo.md
# i2s_rx_stereo

Parametrised I2S receiver: samples SCK/WS/SD from an external I2S microphone or ADC in the system clock domain and captures words of configurable width. It captures left, right or both channels. Completed frames go into a show-ahead FIFO with a valid/ready output handshake and a sticky overflow flag. It sits between the I2S pins and the downstream sample-processing pipeline, and is the multi-channel, back-pressure-capable successor to the single-channel 24-bit capture block.

## Interface
- DATA_W, 24: captured word width, 8..32.
- FIFO_DEPTH, 4: frame FIFO depth, power of two, ≥2.
- MODE, 2: 0 = left only, 1 = right only, 2 = stereo pair.
- clk_i  in  1  system clock; must be ≥4× SCK frequency.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- sck_i  in  1  I2S bit clock, asynchronous.
- ws_i  in  1  I2S word select (0 = left, 1 = right), asynchronous.
- sd_i  in  1  I2S serial data, asynchronous.
- left_o  out  DATA_W  left word of the FIFO head; 0 when empty or MODE=1.
- right_o  out  DATA_W  right word of the FIFO head; 0 when empty or MODE=0.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts the head frame when valid_o & ready_i.
- level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overflow_o  out  1  sticky; a frame was dropped.
- clear_i  in  1  synchronous clear of overflow_o.

## Operation
- sck_i, ws_i and sd_i each pass through an identical 2-flop synchronizer. A third SCK flop provides the edge detect. rise = sck_s2 & ~sck_s3.
- On each rise, sample ws_s2 and sd_s2:
  - Shift sd into the slot register if bit_cnt < DATA_W, MSB first.
  - bit_cnt increments, saturating at DATA_W. Excess slot bits are ignored.
- Slot end: on a rise where ws_s2 ≠ ws_prev. The bit sampled on that rise is the LSB of the ending slot, which is included.
  - The ending slot's channel is ws_prev.
  - word = slot register left-aligned: shifted left by DATA_W − bit_cnt, so a short slot is zero-padded in the LSBs.
  - Then bit_cnt ← 0 and ws_prev ← ws_s2.
- Sync rule: after reset, the first WS transition only arms the block (synced ← 1). Words are emitted only for slots that start after synced is set, so the partial first slot is discarded.
- Frame formation:
  - MODE 0: push {word, 0} at each left slot end.
  - MODE 1: push {0, word} at each right slot end.
  - MODE 2: a left slot end stores word in left_hold and sets hold_v. A right slot end with hold_v set pushes {left_hold, word} and clears hold_v. A right slot end without hold_v pushes nothing.
- FIFO:
  - Push is accepted when not full, or when full and a pop happens in the same cycle.
  - Otherwise the frame is dropped and overflow_o ← 1.
  - Pop = valid_o & ready_i.
  - Simultaneous push and pop leaves level_o unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow_o: clear_i clears it. If a drop and clear_i occur in the same cycle, the drop wins and overflow_o stays 1.

## Timing
- Reset (asynchronous, active-high) values:
  - All outputs 0: valid_o = 0, level_o = 0, overflow_o = 0, left_o = right_o = 0.
  - Internal state cleared: synchronizers, bit_cnt, hold_v, synced, FIFO pointers.
- Reset asserted mid-slot or mid-frame: all partial data is discarded, and the sync rule restarts.
- Latency: let edge E be the clk edge at which the first synchronizer flop samples the SCK rise that ends a slot.
  - The FIFO write occurs at E+2.
  - valid_o, left_o and right_o update after E+2.
  - level_o increments at E+2.
- Pop: the head advances on the clk edge where valid_o & ready_i. The next frame is visible the following cycle; no bubble.
- valid_o is held and left_o/right_o are stable while valid_o=1 and ready_i=0.
- No combinational path from ready_i to valid_o.

## Test plan
- Stereo, DATA_W=24: after a sync slot, send left 0xA5A5A5 and right 0x123456 in 32-bit slots with ready_i=1. Required: one frame with left_o=0xA5A5A5, right_o=0x123456, and valid_o pulsing high for 1 cycle.
- DATA_W=16, MODE=0, 32-bit slots: send left 0xBEEF followed by 16 ones. Required: left_o=0xBEEF, right_o=0, and right slots produce no frames.
- DATA_W=24, 16-bit slot carrying 0xABCD. Required: word 0xABCD00.
- Backpressure, FIFO_DEPTH=4, ready_i=0: send 5 stereo frames. Required:
  - level_o=4 and overflow_o=1 after the 5th frame.
  - Draining yields frames 1–4 in order.
  - clear_i then drops overflow_o to 0.
- Full FIFO: a pop in the same cycle as a push. Required: the push is accepted, level_o stays 4, and overflow_o stays 0.
- Reset mid right slot, then resume. Required:
  - All outputs are 0 during reset.
  - The first post-reset partial slot is discarded.
  - MODE 2: the first emitted frame uses a complete left/right pair.
